apb_periph_node: RTL and testbench

Parametrised APB 1-to-N peripheral node. It is the successor to the fixed 12-port SoC peripheral interconnect.
- Decodes one upstream APB slave port onto NB_SLAVE downstream APB master ports using runtime start/end address ranges and a per-port enable mask.
- Registers the downstream request and the upstream response; adds a decode-error response and a per-access timeout.
- Sits between the SoC AXI-to-APB bridge and the peripherals (UART, GPIO, SPI, timer, DMA, ...).

---
 rtl/apb_periph_node.sv | 217 +++++++++++++++++++++
 tb/tb_apb_periph_node.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_periph_node.sv
// APB 1-to-N peripheral node.
// Decodes one upstream APB slave port onto NB_SLAVE downstream APB master
// ports. Each port is given a runtime address range and an enable bit. The
// downstream request and the upstream response are both registered. An
// address that matches no port is answered with an error, and an access
// phase that runs too long is aborted with an error. Both kinds of error
// are recorded in a small sticky log.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_addr_i/end_addr_i   inclusive per-port ranges, port i at slice i
//   en_mask_i                 per-port decode enable
//   s_p*                      upstream APB slave interface
//   m_p*                      downstream APB master interface; address, write
//                             and wdata are shared by all ports, psel is one-hot
//   err_valid_o               sticky flag: a decode miss or timeout occurred
//   err_timeout_o             1 = logged error was a timeout, 0 = decode miss
//   err_addr_o                address of the first logged error
//   err_clr_i                 clears err_valid_o
module apb_periph_node #(
  parameter int unsigned NB_SLAVE       = 12,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0]   start_addr_i,
  input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0]   end_addr_i,
  input  logic [NB_SLAVE-1:0]                  en_mask_i,
  input  logic [APB_ADDR_WIDTH-1:0]            s_paddr_i,
  input  logic                                 s_psel_i,
  input  logic                                 s_penable_i,
  input  logic                                 s_pwrite_i,
  input  logic [APB_DATA_WIDTH-1:0]            s_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]            s_prdata_o,
  output logic                                 s_pready_o,
  output logic                                 s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]            m_paddr_o,
  output logic                                 m_pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]            m_pwdata_o,
  output logic [NB_SLAVE-1:0]                  m_psel_o,
  output logic                                 m_penable_o,
  input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0]   m_prdata_i,
  input  logic [NB_SLAVE-1:0]                  m_pready_i,
  input  logic [NB_SLAVE-1:0]                  m_pslverr_i,
  output logic                                 err_valid_o,
  output logic                                 err_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0]            err_addr_o,
  input  logic                                 err_clr_i
);

  localparam int unsigned IDX_W  = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES > 0);
  // The counter only has to reach TIMEOUT_CYCLES-1. The abort fires on the
  // last low-ready cycle, and that cycle would be the one that makes the
  // count reach the limit.
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      hit;
  logic [IDX_W-1:0]          hit_idx;
  logic [NB_SLAVE-1:0]       psel_dec;
  logic                      sel_ready;
  logic                      sel_err;
  logic [APB_DATA_WIDTH-1:0] sel_rdata;

  logic                      take;
  logic                      miss;
  logic                      done;
  logic                      tmo;

  // Address decode. The search keeps the first match, so on overlapping
  // ranges the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      if (!hit && en_mask_i[i] &&
          (s_paddr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
          (s_paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Select the latched port: drive its one-hot select bit and pick up its
  // response signals.
  always_comb begin
    psel_dec  = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NB_SLAVE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        psel_dec[i] = 1'b1;
        sel_ready   = m_pready_i[i];
        sel_err     = m_pslverr_i[i];
        sel_rdata   = m_prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    miss        = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
    m_psel_o    = '0;
    m_penable_o = 1'b0;
    s_pready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_psel_i && !s_penable_i) begin
          if (hit) begin
            take    = 1'b1;
            state_d = SETUP;
          end else begin
            miss    = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        m_psel_o = psel_dec;
        state_d  = ACCESS;
      end
      ACCESS: begin
        m_psel_o    = psel_dec;
        m_penable_o = 1'b1;
        // Ready is checked first, so a ready in the limit cycle is a success.
        if (sel_ready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        s_pready_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream request, response capture and access-phase counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      m_paddr_o   <= '0;
      m_pwrite_o  <= 1'b0;
      m_pwdata_o  <= '0;
      s_prdata_o  <= '0;
      s_pslverr_o <= 1'b0;
    end else begin
      if (take) begin
        idx_q      <= hit_idx;
        m_paddr_o  <= s_paddr_i;
        m_pwrite_o <= s_pwrite_i;
        m_pwdata_o <= s_pwdata_i;
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && !sel_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (miss || tmo) begin
        s_prdata_o  <= '0;
        s_pslverr_o <= 1'b1;
      end else if (done) begin
        s_prdata_o  <= m_pwrite_o ? '0 : sel_rdata;
        s_pslverr_o <= sel_err;
      end
    end
  end

  // Sticky error log. The address and cause are captured only when the log
  // is empty or is being cleared in the same cycle, so the first unlogged
  // error is kept. A new error in the clear cycle wins over the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      err_addr_o    <= '0;
    end else if (miss || tmo) begin
      err_valid_o <= 1'b1;
      if (!err_valid_o || err_clr_i) begin
        err_timeout_o <= tmo;
        err_addr_o    <= miss ? s_paddr_i : m_paddr_o;
      end
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_periph_node.sv
// Directed bench for apb_periph_node: 12 ports, timeout of 8 access cycles.
module tb_apb_periph_node;

  localparam int unsigned NB = 12;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst_n;
  logic [NB*AW-1:0]  start_addr;
  logic [NB*AW-1:0]  end_addr;
  logic [NB-1:0]     en_mask;
  logic [AW-1:0]     s_paddr;
  logic              s_psel;
  logic              s_penable;
  logic              s_pwrite;
  logic [DW-1:0]     s_pwdata;
  logic [DW-1:0]     s_prdata;
  logic              s_pready;
  logic              s_pslverr;
  logic [AW-1:0]     m_paddr;
  logic              m_pwrite;
  logic [DW-1:0]     m_pwdata;
  logic [NB-1:0]     m_psel;
  logic              m_penable;
  logic [NB*DW-1:0]  m_prdata;
  logic [NB-1:0]     m_pready;
  logic [NB-1:0]     m_pslverr;
  logic              err_valid;
  logic              err_timeout;
  logic [AW-1:0]     err_addr;
  logic              err_clr;

  int tests  = 0;
  int failed = 0;

  apb_periph_node #(
    .NB_SLAVE       (NB),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_addr_i  (start_addr),
    .end_addr_i    (end_addr),
    .en_mask_i     (en_mask),
    .s_paddr_i     (s_paddr),
    .s_psel_i      (s_psel),
    .s_penable_i   (s_penable),
    .s_pwrite_i    (s_pwrite),
    .s_pwdata_i    (s_pwdata),
    .s_prdata_o    (s_prdata),
    .s_pready_o    (s_pready),
    .s_pslverr_o   (s_pslverr),
    .m_paddr_o     (m_paddr),
    .m_pwrite_o    (m_pwrite),
    .m_pwdata_o    (m_pwdata),
    .m_psel_o      (m_psel),
    .m_penable_o   (m_penable),
    .m_prdata_i    (m_prdata),
    .m_pready_i    (m_pready),
    .m_pslverr_i   (m_pslverr),
    .err_valid_o   (err_valid),
    .err_timeout_o (err_timeout),
    .err_addr_o    (err_addr),
    .err_clr_i     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents the upstream setup phase in the current cycle. Returns one cycle
  // later with the upstream now in its access phase.
  task automatic start_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    s_psel    = 1'b1;
    s_penable = 1'b0;
    s_paddr   = a;
    s_pwrite  = w;
    s_pwdata  = d;
    tick;
    s_penable = 1'b1;
    err_clr   = 1'b0;
  endtask

  task automatic end_xfer;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    err_clr   = 1'b0;
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    err_clr   = 1'b0;
    en_mask   = '1;
    m_pready  = '1;
    m_pslverr = '0;
    for (int i = 0; i < NB; i++) begin
      start_addr[i*AW +: AW] = 32'h1A10_0000 + i * 32'h1000;
      end_addr[i*AW +: AW]   = 32'h1A10_0FFF + i * 32'h1000;
      m_prdata[i*DW +: DW]   = 32'hA000_0000 | i;
    end
    m_prdata[3*DW +: DW] = 32'hDEAD_BEEF;

    #2;
    chk("rst_psel", m_psel, 0);
    chk("rst_penable", m_penable, 0);
    chk("rst_pready", s_pready, 0);
    chk("rst_prdata", s_prdata, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_paddr", m_paddr, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    // Zero-wait read from port 3
    start_xfer(32'h1A10_3004, 1'b0, 32'h0);
    chk("zw_c1_psel", m_psel, 12'h008);
    chk("zw_c1_penable", m_penable, 0);
    chk("zw_c1_paddr", m_paddr, 32'h1A10_3004);
    chk("zw_c1_pready", s_pready, 0);
    tick;
    chk("zw_c2_psel", m_psel, 12'h008);
    chk("zw_c2_penable", m_penable, 1);
    chk("zw_c2_pready", s_pready, 0);
    tick;
    chk("zw_c3_pready", s_pready, 1);
    chk("zw_c3_prdata", s_prdata, 32'hDEAD_BEEF);
    chk("zw_c3_pslverr", s_pslverr, 0);
    chk("zw_c3_psel", m_psel, 0);
    end_xfer;
    chk("zw_c4_pready", s_pready, 0);

    // Wait-state write to port 11 that ends with a slave error
    m_pready[11]  = 1'b0;
    m_pslverr[11] = 1'b1;
    start_xfer(32'h1A10_B010, 1'b1, 32'h1234_5678);
    chk("ws_c1_psel", m_psel, 12'h800);
    chk("ws_c1_pwrite", m_pwrite, 1);
    chk("ws_c1_pwdata", m_pwdata, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("ws_wait_penable", m_penable, 1);
      chk("ws_wait_pwdata", m_pwdata, 32'h1234_5678);
      chk("ws_wait_pready", s_pready, 0);
    end
    tick;
    m_pready[11] = 1'b1;
    chk("ws_rdy_psel", m_psel, 12'h800);
    tick;
    chk("ws_resp_pready", s_pready, 1);
    chk("ws_resp_pslverr", s_pslverr, 1);
    chk("ws_resp_prdata", s_prdata, 0);
    chk("ws_resp_psel", m_psel, 0);
    chk("ws_err_valid", err_valid, 0);
    m_pslverr[11] = 1'b0;
    end_xfer;

    // Decode misses and the error log
    start_xfer(32'h2000_0000, 1'b0, 32'h0);
    chk("miss_psel", m_psel, 0);
    chk("miss_pready", s_pready, 1);
    chk("miss_pslverr", s_pslverr, 1);
    chk("miss_prdata", s_prdata, 0);
    chk("miss_err_valid", err_valid, 1);
    chk("miss_err_addr", err_addr, 32'h2000_0000);
    chk("miss_err_timeout", err_timeout, 0);
    chk("miss_paddr_held", m_paddr, 32'h1A10_B010);
    end_xfer;
    start_xfer(32'h3000_0000, 1'b0, 32'h0);
    chk("miss2_pready", s_pready, 1);
    chk("miss2_err_addr", err_addr, 32'h2000_0000);
    end_xfer;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr_err_valid", err_valid, 0);
    start_xfer(32'h2000_0000, 1'b0, 32'h0);
    end_xfer;
    err_clr = 1'b1;
    start_xfer(32'h4000_0000, 1'b0, 32'h0);
    chk("clrmiss_err_valid", err_valid, 1);
    chk("clrmiss_err_addr", err_addr, 32'h4000_0000);
    end_xfer;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr2_err_valid", err_valid, 0);

    // Timeout: port 3 never ready, so ACCESS lasts 8 cycles
    m_pready[3] = 1'b0;
    start_xfer(32'h1A10_3008, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("tmo_access_penable", m_penable, 1);
      chk("tmo_access_psel", m_psel, 12'h008);
    end
    tick;
    chk("tmo_psel", m_psel, 0);
    chk("tmo_pready", s_pready, 1);
    chk("tmo_pslverr", s_pslverr, 1);
    chk("tmo_prdata", s_prdata, 0);
    chk("tmo_err_valid", err_valid, 1);
    chk("tmo_err_timeout", err_timeout, 1);
    chk("tmo_err_addr", err_addr, 32'h1A10_3008);
    end_xfer;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;

    // Ready in the 8th access cycle still counts as success
    start_xfer(32'h1A10_3008, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++) tick;
    tick;
    m_pready[3] = 1'b1;
    chk("lim_psel", m_psel, 12'h008);
    tick;
    chk("lim_pready", s_pready, 1);
    chk("lim_pslverr", s_pslverr, 0);
    chk("lim_prdata", s_prdata, 32'hDEAD_BEEF);
    chk("lim_err_valid", err_valid, 0);
    end_xfer;

    // Overlapping ranges and the enable mask
    start_addr[1*AW +: AW] = 32'h0000_0000;
    end_addr[1*AW +: AW]   = 32'h0000_01FF;
    start_addr[5*AW +: AW] = 32'h0000_0100;
    end_addr[5*AW +: AW]   = 32'h0000_02FF;
    start_xfer(32'h0000_0100, 1'b0, 32'h0);
    chk("ovl_psel", m_psel, 12'h002);
    tick;
    tick;
    chk("ovl_prdata", s_prdata, 32'hA000_0001);
    end_xfer;
    en_mask[1] = 1'b0;
    start_xfer(32'h0000_0100, 1'b0, 32'h0);
    chk("mask_psel", m_psel, 12'h020);
    tick;
    tick;
    chk("mask_prdata", s_prdata, 32'hA000_0005);
    end_xfer;
    en_mask[5] = 1'b0;
    start_xfer(32'h0000_0100, 1'b0, 32'h0);
    chk("maskmiss_psel", m_psel, 0);
    chk("maskmiss_pready", s_pready, 1);
    chk("maskmiss_pslverr", s_pslverr, 1);
    end_xfer;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;

    // Reset asserted during ACCESS
    m_pready[11] = 1'b0;
    start_xfer(32'h1A10_B000, 1'b0, 32'h0);
    tick;
    chk("rsta_penable", m_penable, 1);
    rst_n = 1'b0;
    #1;
    chk("rsta_psel", m_psel, 0);
    chk("rsta_penable_low", m_penable, 0);
    chk("rsta_pready", s_pready, 0);
    s_psel    = 1'b0;
    s_penable = 1'b0;
    m_pready  = '1;
    #2;
    rst_n = 1'b1;
    tick;
    start_xfer(32'h1A10_3004, 1'b0, 32'h0);
    chk("post_rst_psel", m_psel, 12'h008);
    tick;
    tick;
    chk("post_rst_pready", s_pready, 1);
    chk("post_rst_prdata", s_prdata, 32'hDEAD_BEEF);
    end_xfer;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
